// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch constants and helpers used by fetch, decode and instruction memory.
// Pure definitions: no latency, no flow control.
package legv8_fetch_pkg;
    localparam int unsigned    INSTR_W          = 32;
    localparam int unsigned    INSTR_BYTES      = 4;
    localparam int unsigned    WORD_ADDR_SHIFT  = 2;
    localparam logic [31:0]    DEFAULT_RESET_PC = 32'h0000_0000;

    typedef logic [INSTR_W-1:0] instr_t;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr >> WORD_ADDR_SHIFT;
    endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port on one side, decode port on the other.
// master = fetch unit, slave = memory/decode environment.
interface instruction_fetch_unit_if #(
    parameter int unsigned COUNT_W = 16
);
    import legv8_fetch_pkg::*;

    logic [31:0]        imem_address;
    instr_t             imem_instruction;
    logic               id_stall;
    logic               branch_taken;
    logic [31:0]        branch_target;
    instr_t             if_instruction;
    logic [31:0]        if_pc;
    logic               if_valid;
    logic [COUNT_W-1:0] fetch_count;

    modport master (
        output imem_address, if_instruction, if_pc, if_valid, fetch_count,
        input  imem_instruction, id_stall, branch_taken, branch_target
    );

    modport slave (
        input  imem_address, if_instruction, if_pc, if_valid, fetch_count,
        output imem_instruction, id_stall, branch_taken, branch_target
    );
endinterface

// File: rtl/instruction_fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Increments on the edge after en=1; holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// PC generation and fetch control; instruction visible to decode 1 cycle after its address.
// id_stall re-presents the held PC so memory data stays stable; branch_taken overrides stall.
module instruction_fetch_unit
    import legv8_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = INSTR_BYTES,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    instruction_fetch_unit_if.master  bus
);
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    logic [31:0] fetch_pc;
    logic [31:0] resp_pc;
    logic        resp_valid;
    logic        count_en;

    // A stalled cycle re-reads the word decode is holding so the synchronous read stays put.
    always_comb begin
        if (!reset_n) begin
            bus.imem_address = word_addr(RESET_PC_ALIGNED);
        end else if (bus.id_stall && !bus.branch_taken) begin
            bus.imem_address = word_addr(resp_pc);
        end else begin
            bus.imem_address = word_addr(fetch_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc   <= RESET_PC_ALIGNED;
            resp_pc    <= '0;
            resp_valid <= 1'b0;
        end else if (bus.branch_taken) begin
            fetch_pc   <= bus.branch_target & ~32'h3;
            resp_valid <= 1'b0;
        end else if (!bus.id_stall) begin
            resp_pc    <= fetch_pc;
            resp_valid <= 1'b1;
            fetch_pc   <= fetch_pc + 32'(PC_STEP);
        end
    end

    assign bus.if_pc          = resp_pc;
    assign bus.if_valid       = resp_valid;
    assign bus.if_instruction = bus.imem_instruction;

    assign count_en = resp_valid && !bus.id_stall && !bus.branch_taken;

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_fetch_count (
        .clk   (clk),
        .clr_n (reset_n),
        .en    (count_en),
        .count (bus.fetch_count)
    );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Drives two fetch units (default and wrap/small-counter configs) with shared stimulus
// and compares each against a transaction-level model of the fetch stream.
module tb_instruction_fetch_unit;
    import legv8_fetch_pkg::*;

    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        br;
    logic [31:0] tgt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.COUNT_W(16)) bus0 ();
    instruction_fetch_unit_if #(.COUNT_W(2))  bus1 ();

    instruction_fetch_unit #(.RESET_PC(32'h0), .PC_STEP(4), .COUNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    instruction_fetch_unit #(.RESET_PC(RPC1), .PC_STEP(4), .COUNT_W(2)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    assign bus0.id_stall = stall;  assign bus1.id_stall = stall;
    assign bus0.branch_taken = br; assign bus1.branch_taken = br;
    assign bus0.branch_target = tgt; assign bus1.branch_target = tgt;

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        case (wa)
            32'd0:   return 32'h0;
            32'd1:   return 32'hAA80_0000;
            32'd2:   return 32'h8;
            default: return (wa * 32'h9E37_79B1) ^ 32'h1234_5678;
        endcase
    endfunction

    // Behavioural synchronous-read instruction memories.
    always @(posedge clk) begin
        bus0.imem_instruction <= mem_word(bus0.imem_address);
        bus1.imem_instruction <= mem_word(bus1.imem_address);
    end

    logic [31:0] o_addr[2], o_pc[2], o_ins[2], o_cnt[2];
    logic        o_val[2];
    assign o_addr[0] = bus0.imem_address;   assign o_addr[1] = bus1.imem_address;
    assign o_pc[0]   = bus0.if_pc;          assign o_pc[1]   = bus1.if_pc;
    assign o_ins[0]  = bus0.if_instruction; assign o_ins[1]  = bus1.if_instruction;
    assign o_cnt[0]  = 32'(bus0.fetch_count); assign o_cnt[1] = 32'(bus1.fetch_count);
    assign o_val[0]  = bus0.if_valid;       assign o_val[1]  = bus1.if_valid;

    // Model: next PC to fetch, the PC currently offered to decode, and accepted count.
    logic [31:0] m_next[2], m_out_pc[2];
    bit          m_out_val[2];
    int unsigned m_cnt[2];

    function automatic logic [31:0] boot_pc(input int k);
        return (k == 0) ? 32'h0 : RPC1;
    endfunction

    function automatic int unsigned cnt_max(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_next[k] = boot_pc(k) & ~32'h3;
                m_out_pc[k] = 32'h0;
                m_out_val[k] = 1'b0;
                m_cnt[k] = 0;
            end else if (br) begin
                m_next[k] = {tgt[31:2], 2'b00};
                m_out_val[k] = 1'b0;
            end else if (!stall) begin
                if (m_out_val[k] && m_cnt[k] < cnt_max(k)) m_cnt[k]++;
                m_out_pc[k] = m_next[k];
                m_out_val[k] = 1'b1;
                m_next[k] = m_next[k] + 32'd4;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit b, input logic [31:0] t);
        logic [31:0] exp_addr;
        @(negedge clk);
        reset_n = r; stall = s; br = b; tgt = t;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!reset_n)        exp_addr = (boot_pc(k) & ~32'h3) / 4;
            else if (s && !b)    exp_addr = m_out_pc[k] / 4;
            else                 exp_addr = m_next[k] / 4;
            chk($sformatf("addr%0d", k), o_addr[k], exp_addr);
            chk($sformatf("valid%0d", k), 32'(o_val[k]), 32'(m_out_val[k]));
            chk($sformatf("pc%0d", k), o_pc[k], m_out_pc[k]);
            chk($sformatf("count%0d", k), o_cnt[k], 32'(m_cnt[k]));
            if (m_out_val[k])
                chk($sformatf("instr%0d", k), o_ins[k], mem_word(m_out_pc[k] / 4));
        end
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; br = 1'b0; tgt = 32'h0;
        @(posedge clk);
        model_edge();
        cycle(0, 0, 0, 0);
        // Six clean cycles: the wrap config walks FFFF_FFF8 -> 0 and saturates its count.
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);
        #1;
        chk("wrap_pc", bus1.if_pc, 32'h0000_000C);
        chk("wrap_cnt_sat", 32'(bus1.fetch_count), 32'd3);
        chk("dflt_cnt", 32'(bus0.fetch_count), 32'd5);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 32'h20);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 32'h13);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 32'h40);
        cycle(1, 0, 1, 32'h84);
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            bit r, s, b;
            r = ($urandom_range(0, 49) != 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            cycle(r, s, b, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Program-counter and fetch-control stage directly upstream of the 32-bit instruction memory.
- Drives the memory's word address and pairs each returned instruction with its byte PC.
- Presents a valid-tagged instruction to decode.
- Handles the memory's 1-cycle synchronous read latency, decode stalls, and branch redirects (squashing the wrong-path instruction).

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- PC_STEP, 4, byte increment per sequential fetch.
- COUNT_W, 16, width of the delivered-instruction counter.

Ports:
- clk  in  1  rising-edge clock shared with instruction memory
- reset_n  in  1  synchronous active-low reset
- imem_address  out  32  word address to instruction memory = {2'b00, pc[31:2]}
- imem_instruction  in  32  instruction memory read data (valid 1 cycle after address)
- id_stall  in  1  decode cannot accept this cycle; hold output
- branch_taken  in  1  redirect request
- branch_target  in  32  redirect byte address; bits [1:0] ignored (treated as 0)
- if_instruction  out  32  instruction to decode (pass-through of imem_instruction)
- if_pc  out  32  byte PC of if_instruction
- if_valid  out  1  if_instruction/if_pc are a real, non-squashed instruction
- fetch_count  out  COUNT_W  instructions accepted by decode, saturating

Behaviour:
- Registers:
  - fetch_pc: next address to present.
  - resp_pc: address presented last cycle.
  - resp_valid, fetch_count.
- Reset (reset_n=0 at a clk edge):
  - fetch_pc<=RESET_PC with bits [1:0] cleared; resp_pc<=0; resp_valid<=0; fetch_count<=0.
  - During reset cycles imem_address = RESET_PC>>2.
- Outputs:
  - if_pc=resp_pc, if_valid=resp_valid, if_instruction=imem_instruction (combinational, no extra register).
  - Total latency PC-presented to decode-visible: 1 cycle.
- Address mux (combinational): imem_address = id_stall && !branch_taken ? resp_pc>>2 : fetch_pc>>2.
  - Re-presenting resp_pc during a stall makes the memory re-read the same word, so if_instruction stays stable across any stall length.
- Per-edge update, priority order:
  1. Reset.
  2. branch_taken=1:
     - fetch_pc<=target&~3; resp_valid<=0 (squash the in-flight instruction); resp_pc<=resp_pc.
     - Applies even when id_stall=1.
  3. id_stall=1:
     - fetch_pc, resp_pc and resp_valid all hold.
  4. Otherwise:
     - resp_pc<=fetch_pc; resp_valid<=1; fetch_pc<=fetch_pc+PC_STEP.
- After a redirect:
  - The cycle following the redirect presents the target address with if_valid=0.
  - The next cycle delivers the target with if_valid=1.
  - Redirect penalty is 1 bubble.
- Back-to-back redirects: the last one wins; if_valid stays 0 until one non-redirect, non-stall cycle completes.
- PC arithmetic: modulo 2^32. 0xFFFF_FFFC+4 wraps to 0 with no flag.
- fetch_count:
  - Increments when if_valid=1, id_stall=0 and branch_taken=0.
  - Saturates at 2^COUNT_W-1.
  - Reset-only clear.
- Reset mid-stall or mid-redirect: reset dominates; the state above applies on the next edge.

Decomposition:
- Shared package legv8_fetch_pkg:
  - INSTR_BYTES=4, WORD_ADDR_SHIFT=2, default RESET_PC, INSTR_W=32.
  - Reused by decode and the instruction memory.
- One natural sub-module: sat_counter (COUNT_W-wide, enable, synchronous active-low clear, saturating), instantiated for fetch_count.
- The PC/valid logic stays in the top block.

Test Plan:
- Reset sequence: hold reset_n=0 for 2 cycles, then release with no stall/branch.
  - imem_address goes 0,1,2,3.
  - if_valid goes 0 then 1 from the 2nd post-reset cycle.
  - if_pc goes 0,4,8.
  - With the memory preloaded (word1=0xAA800000, word2=8), if_instruction follows 0, 0xAA800000, 8.
- Stall: at if_pc=4, hold id_stall=1 for 3 cycles.
  - if_pc stays 4, if_instruction stays 0xAA800000, if_valid stays 1, imem_address=1 throughout, fetch_count frozen.
  - After release, if_pc continues 8, 12.
- Redirect: branch_taken=1 with branch_target=0x20 while if_pc=8.
  - Next cycle: if_valid=0, imem_address=8.
  - Following cycle: if_valid=1, if_pc=0x20.
  - The squashed instruction is not counted.
- Redirect during stall plus misaligned target: id_stall=1, branch_taken=1, target=0x13.
  - Redirect wins; fetch goes to 0x10; one bubble.
- Wrap and saturation: with RESET_PC=0xFFFF_FFF8 and COUNT_W=2, run 6 unstalled cycles.
  - if_pc goes FFFF_FFF8, FFFF_FFFC, 0, 4.
  - fetch_count stops at 3.
- Reset mid-stream: assert reset_n=0 for one cycle while if_valid=1 and id_stall=1.
  - Next cycle: if_valid=0, fetch_count=0, imem_address=RESET_PC>>2.
